dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters: m0 (pipeline MEM stage) and m1 (debug/loader port).
//   Runs a 3-state FSM: arbitrate, drive exactly one memory access, return data with a one-cycle ack.
//   Sits between the requesters and the dm addr/data_in/MemWrite/MemRead/data_out pins.
//   The dm word-addresses internally (addr>>2); this block passes byte addresses through unchanged.
// PARAMETERS
//   AW           32  address width, all addr ports
//   DW           32  data width, all data ports
//   M0_PRIORITY  0   0 = round-robin on contention; 1 = m0 always wins contention
// PORTS
//   clk          in   1   rising-edge clock shared with dm
//   reset        in   1   synchronous, active-low reset
//   m0_req       in   1   m0 request; hold with payload stable until m0_ack
//   m0_we        in   1   1 = write, 0 = read
//   m0_addr      in   AW  byte address
//   m0_wdata     in   DW  write data
//   m0_ack       out  1   one-cycle pulse: access complete
//   m0_rdata     out  DW  read data, valid while m0_ack=1
//   m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata   same as m0_*, for m1
//   dm_addr      out  AW  to dm addr
//   dm_data_in   out  DW  to dm data_in
//   dm_MemWrite  out  1   to dm MemWrite
//   dm_MemRead   out  1   to dm MemRead
//   dm_data_out  in   DW  from dm data_out (combinational read)
//   busy         out  1   1 when the FSM is not IDLE
// BEHAVIOUR
//   Reset (reset=0 at posedge): state=IDLE, last_grant=m1, all outputs 0, latched addr/wdata/we/owner cleared.
//   States:
//     IDLE:   pick winner from {m0_req,m1_req}; latch owner, we, addr, wdata; go to ACCESS. No request: stay.
//     ACCESS: dm_addr=addr_r, dm_data_in=wdata_r, dm_MemWrite=we_r, dm_MemRead=~we_r.
//             Write commits at the closing edge; dm_data_out captured into rdata_r at the same edge.
//             Always go to RESP.
//     RESP:   owner's ack=1 and owner's rdata=rdata_r for this cycle only.
//             Writes return rdata=0. The other master's ack=0 and its rdata holds its previous value.
//             Arbitrate as in IDLE, but ignore the current owner's req this cycle.
//             Winner: latch and go to ACCESS. No winner: go to IDLE.
//   dm_* outputs are 0 outside ACCESS.
//   dm_MemWrite = (state==ACCESS) & we_r & reset; reset low suppresses an in-flight write in the same cycle.
//   Latency: req seen in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2.
//   Back-to-back throughput: one access per 2 cycles (RESP->ACCESS).
//   Arbitration:
//     One requester: that requester wins.
//     Both requesting, M0_PRIORITY=0: the master not equal to last_grant wins; last_grant updates on every grant.
//     Both requesting, M0_PRIORITY=1: m0 wins.
//   A master never receives ack without a prior grant; acks to m0 and m1 never occur in the same cycle.
//   Reset low in ACCESS or RESP: access abandoned, no ack issued, state=IDLE next cycle.
//   Requester drops req before ack: the access still completes and ack still pulses (protocol violation, not an error).
//   Address and data pass through at full width; alignment is handled by dm.
// TESTING
//   1. Reset low 2 cycles with both reqs high -> acks 0, dm_MemWrite 0, busy 0 throughout.
//   2. m0 write addr=0x8 wdata=0xDEADBEEF, then m0 read addr=0x8 -> ack 2 cycles after each IDLE sample; m0_rdata=0xDEADBEEF.
//   3. m0, m1 both reading constantly, M0_PRIORITY=0 -> acks alternate m0,m1,m0,m1; one ack every 2 cycles after the first.
//   4. Same stimulus, M0_PRIORITY=1 -> m1 never acked while m0_req stays high.
//      Drop m0_req -> m1 acked within 2 cycles.
//   5. m1 write 0x12345678 to 0x4; reset pulsed low during the ACCESS cycle -> no ack; dm word 1 unchanged.
//      A following read of 0x4 returns the old value.
//   6. m1 requests in the same cycle m0 is in RESP -> ACCESS for m1 next cycle, m1_ack 2 cycles later; m0_ack exactly one cycle wide.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single-port data memory: arbitrate, drive one access, ack.
// Byte addresses and data pass through at full width; dm handles word addressing.
module dm_port_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter bit          M0_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_data_in,
    output logic          dm_MemWrite,
    output logic          dm_MemRead,
    input  logic [DW-1:0] dm_data_out,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;            // 0 = m0, 1 = m1
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic cand0, cand1, grant_valid, grant_sel;

    // In RESP the owner's req is still the one just served, so it is masked;
    // m0-priority mode keeps m0 ahead whenever both lines are raised.
    always_comb begin
        cand0 = m0_req;
        cand1 = m1_req;
        if ((state_q == RESP) && !(M0_PRIORITY && m0_req && m1_req)) begin
            if (owner_q) cand1 = 1'b0;
            else         cand0 = 1'b0;
        end
        grant_valid = cand0 | cand1;
        if (cand0 && cand1) grant_sel = M0_PRIORITY ? 1'b0 : ~last_grant_q;
        else                grant_sel = cand1;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (grant_valid) begin
                    state_d      = ACCESS;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    we_d         = grant_sel ? m1_we    : m0_we;
                    addr_d       = grant_sel ? m1_addr  : m0_addr;
                    wdata_d      = grant_sel ? m1_wdata : m0_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (owner_q) m1_rdata_d = we_q ? '0 : dm_data_out;
                else         m0_rdata_d = we_q ? '0 : dm_data_out;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Acks and the write strobe are gated by reset so an abandoned access never completes.
    always_comb begin
        m0_ack      = reset && (state_q == RESP) && !owner_q;
        m1_ack      = reset && (state_q == RESP) && owner_q;
        m0_rdata    = m0_rdata_q;
        m1_rdata    = m1_rdata_q;
        dm_addr     = (state_q == ACCESS) ? addr_q  : '0;
        dm_data_in  = (state_q == ACCESS) ? wdata_q : '0;
        dm_MemWrite = (state_q == ACCESS) && we_q && reset;
        dm_MemRead  = (state_q == ACCESS) && !we_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: round-robin instance with a memory model,
// plus an m0-priority instance for the contention case.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dm_addr, dm_data_in, dm_data_out;
    logic        dm_MemWrite, dm_MemRead, busy;

    logic        p_m0_req, p_m1_req;
    logic        p_m0_ack, p_m1_ack;
    logic [31:0] p_m0_rdata, p_m1_rdata;
    logic [31:0] p_dm_addr, p_dm_data_in, p_dm_data_out;
    logic        p_dm_MemWrite, p_dm_MemRead, p_busy;

    logic [31:0] mem [0:15];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned waited;

    always #5 clk = ~clk;

    always @(posedge clk) if (dm_MemWrite) mem[dm_addr[5:2]] <= dm_data_in;
    assign dm_data_out   = mem[dm_addr[5:2]];
    assign p_dm_data_out = ~p_dm_addr;

    dm_port_arbiter #(.AW(32), .DW(32), .M0_PRIORITY(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_MemWrite(dm_MemWrite),
        .dm_MemRead(dm_MemRead), .dm_data_out(dm_data_out), .busy(busy)
    );

    dm_port_arbiter #(.AW(32), .DW(32), .M0_PRIORITY(1'b1)) dut_p (
        .clk(clk), .reset(reset),
        .m0_req(p_m0_req), .m0_we(1'b0), .m0_addr(32'h10), .m0_wdata(32'h0),
        .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata),
        .m1_req(p_m1_req), .m1_we(1'b0), .m1_addr(32'h20), .m1_wdata(32'h0),
        .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata),
        .dm_addr(p_dm_addr), .dm_data_in(p_dm_data_in), .dm_MemWrite(p_dm_MemWrite),
        .dm_MemRead(p_dm_MemRead), .dm_data_out(p_dm_data_out), .busy(p_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_exp [0:7];
        rr_exp[0] = 2'b00; rr_exp[1] = 2'b01; rr_exp[2] = 2'b00; rr_exp[3] = 2'b10;
        rr_exp[4] = 2'b00; rr_exp[5] = 2'b01; rr_exp[6] = 2'b00; rr_exp[7] = 2'b10;

        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        p_m0_req = 1'b1; p_m1_req = 1'b1;

        // 1: reset held with both requests raised
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_m0_ack", {31'b0, m0_ack}, 32'd0);
            check("rst_m1_ack", {31'b0, m1_ack}, 32'd0);
            check("rst_memwrite", {31'b0, dm_MemWrite}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_p_busy", {31'b0, p_busy}, 32'd0);
        end
        reset = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; p_m0_req = 1'b0; p_m1_req = 1'b0;
        step();

        // 2: m0 write then read back
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8; m0_wdata = 32'hDEADBEEF;
        step();
        check("wr_access_memwrite", {31'b0, dm_MemWrite}, 32'd1);
        check("wr_access_addr", dm_addr, 32'h8);
        check("wr_access_data", dm_data_in, 32'hDEADBEEF);
        check("wr_access_noack", {31'b0, m0_ack}, 32'd0);
        check("wr_access_busy", {31'b0, busy}, 32'd1);
        step();
        check("wr_ack", {31'b0, m0_ack}, 32'd1);
        check("wr_rdata_zero", m0_rdata, 32'd0);
        check("wr_memwrite_off", {31'b0, dm_MemWrite}, 32'd0);
        m0_req = 1'b0;
        step();
        check("wr_idle_busy", {31'b0, busy}, 32'd0);
        check("wr_idle_noack", {31'b0, m0_ack}, 32'd0);
        m0_req = 1'b1; m0_we = 1'b0;
        step();
        check("rd_access_memread", {31'b0, dm_MemRead}, 32'd1);
        check("rd_access_nowrite", {31'b0, dm_MemWrite}, 32'd0);
        step();
        check("rd_ack", {31'b0, m0_ack}, 32'd1);
        check("rd_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_other_noack", {31'b0, m1_ack}, 32'd0);
        m0_req = 1'b0;
        step();

        // 3: round-robin contention; last grant was m0, so m1 goes first
        m0_req = 1'b1; m0_addr = 32'h8; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr_acks_%0d", i), {30'b0, m0_ack, m1_ack}, {30'b0, rr_exp[i]});
        end
        check("rr_m1_rdata", m1_rdata, 32'hDEADBEEF);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        check("rr_idle_busy", {31'b0, busy}, 32'd0);

        // 4: m0 priority holds m1 off while m0_req stays high
        p_m0_req = 1'b1; p_m1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("pri_m1_ack_%0d", i), {31'b0, p_m1_ack}, 32'd0);
            check($sformatf("pri_m0_ack_%0d", i), {31'b0, p_m0_ack}, {31'b0, i[0]});
        end
        check("pri_m0_rdata", p_m0_rdata, 32'hFFFF_FFEF);
        p_m0_req = 1'b0;
        waited = 0;
        while (!p_m1_ack && waited < 4) begin
            step();
            waited++;
        end
        check("pri_m1_ack_seen", {31'b0, p_m1_ack}, 32'd1);
        check("pri_m1_latency", waited, 32'd2);
        check("pri_m1_rdata", p_m1_rdata, 32'hFFFF_FFDF);
        p_m1_req = 1'b0;
        step();

        // 5: write abandoned by reset during ACCESS
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4; m1_wdata = 32'hCAFEF00D;
        step();
        step();
        check("pre_wr_ack", {31'b0, m1_ack}, 32'd1);
        m1_req = 1'b0;
        step();
        m1_req = 1'b1; m1_wdata = 32'h12345678;
        step();
        reset = 1'b0;
        #1;
        check("abort_memwrite", {31'b0, dm_MemWrite}, 32'd0);
        step();
        check("abort_noack", {31'b0, m1_ack}, 32'd0);
        check("abort_idle", {31'b0, busy}, 32'd0);
        reset = 1'b1; m1_req = 1'b0;
        step();
        check("abort_noack_after", {31'b0, m1_ack}, 32'd0);
        check("abort_mem_word1", mem[1], 32'hCAFEF00D);
        m1_req = 1'b1; m1_we = 1'b0;
        step();
        step();
        check("abort_rd_ack", {31'b0, m1_ack}, 32'd1);
        check("abort_rd_old", m1_rdata, 32'hCAFEF00D);
        m1_req = 1'b0;
        step();

        // 6: m1 raises req while m0 sits in RESP
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
        step();
        step();
        check("hand_m0_ack", {31'b0, m0_ack}, 32'd1);
        m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        step();
        check("hand_m0_ack_width", {31'b0, m0_ack}, 32'd0);
        check("hand_m1_access", dm_addr, 32'h4);
        check("hand_busy", {31'b0, busy}, 32'd1);
        step();
        check("hand_m1_ack", {31'b0, m1_ack}, 32'd1);
        check("hand_m1_rdata", m1_rdata, 32'hCAFEF00D);
        check("hand_m0_quiet", {31'b0, m0_ack}, 32'd0);
        check("hand_m0_hold", m0_rdata, 32'hDEADBEEF);
        m1_req = 1'b0;
        step();
        check("hand_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
